// File: rtl/div_ctrl.sv
// Run-time controller for the counter-based clock divider: start/stop on period
// boundaries and glitch-free ratio updates. Define DIV_CTRL_WRAP_CNT_EN to add the wrap_cnt output.
module div_ctrl #(
   parameter int          CNT_W    = 16,
   parameter int unsigned DEF_TERM = 56187
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             clk_div,
   output logic             tick,
   output logic             busy
`ifdef DIV_CTRL_WRAP_CNT_EN
   ,
   output logic [15:0]      wrap_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [CNT_W-1:0] TERM_RST = CNT_W'(DEF_TERM);
   localparam logic [CNT_W:0]   INC_RST  = {1'b0, TERM_RST} + (CNT_W+1)'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_nxt;
   logic [CNT_W-1:0] term;
   logic [CNT_W-1:0] term_nxt;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] half_nxt;
   logic [CNT_W-1:0] pend;
   logic [CNT_W-1:0] pend_nxt;
   logic             pend_v;
   logic             pend_v_nxt;
   logic [CNT_W-1:0] cfg_val;
   logic [CNT_W:0]   term_inc;
   logic             wrap;
   logic             xfer;
   logic             clk_div_nxt;

   assign cfg_ready = !pend_v;
   assign busy      = (state != IDLE);
   assign xfer      = cfg_valid && !pend_v;
   assign wrap      = (state != IDLE) && (counter == term);
   // A zero ratio would stall the divider, so the shortest legal period is 2.
   assign cfg_val   = (cfg_div == '0) ? CNT_W'(1) : cfg_div;

   always_comb begin
      state_nxt   = state;
      counter_nxt = '0;
      case (state)
         IDLE: begin
            if (en) state_nxt = RUN;
         end
         RUN, DRAIN: begin
            counter_nxt = wrap ? '0 : counter + CNT_W'(1);
            if (wrap && !en) state_nxt = IDLE;
            else if (en)     state_nxt = RUN;
            else             state_nxt = DRAIN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ratio changes only land while stopped or on a wrap edge, so no period is ever cut short.
   always_comb begin
      term_nxt   = term;
      pend_nxt   = pend;
      pend_v_nxt = pend_v;
      if (xfer) begin
         if (state == IDLE || wrap) begin
            term_nxt = cfg_val;
         end else begin
            pend_nxt   = cfg_val;
            pend_v_nxt = 1'b1;
         end
      end else if (pend_v && wrap) begin
         term_nxt   = pend;
         pend_v_nxt = 1'b0;
      end
      term_inc    = {1'b0, term_nxt} + (CNT_W+1)'(1);
      half_nxt    = term_inc[CNT_W:1];
      clk_div_nxt = (counter_nxt >= half_nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         counter <= '0;
         term    <= TERM_RST;
         half    <= INC_RST[CNT_W:1];
         pend    <= '0;
         pend_v  <= 1'b0;
         tick    <= 1'b0;
         clk_div <= 1'b0;
      end else begin
         state   <= state_nxt;
         counter <= counter_nxt;
         term    <= term_nxt;
         half    <= half_nxt;
         pend    <= pend_nxt;
         pend_v  <= pend_v_nxt;
         tick    <= wrap;
         clk_div <= clk_div_nxt;
      end
   end

`ifdef DIV_CTRL_WRAP_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_cnt <= '0;
      end else if (state == IDLE && en) begin
         wrap_cnt <= '0;
      end else if (wrap && wrap_cnt != 16'hFFFF) begin
         wrap_cnt <= wrap_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: expected tick cycles go into a scoreboard queue that a
// negedge monitor drains; level outputs are checked inline against hand-derived patterns.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        cfg_valid;
   logic [15:0] cfg_div;
   logic        cfg_ready;
   logic        clk_div;
   logic        tick;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int expTicks[$];

   int b, b3, b5, b6, b7, r, staticBad;
   logic patA [8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic patB [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   div_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .clk_div   (clk_div),
      .tick      (tick),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic v, input logic [15:0] d);
      en        = e;
      cfg_valid = v;
      cfg_div   = d;
   endtask

   task automatic waitUntil(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Scoreboard monitor: every tick must land exactly on the next queued cycle.
   always @(negedge clk) begin
      while (expTicks.size() > 0 && expTicks[0] < cyc) begin
         checkOutput("tick_missed", cyc, expTicks[0]);
         void'(expTicks.pop_front());
      end
      if (tick) begin
         if (expTicks.size() == 0) begin
            checkOutput("tick_unexpected", cyc, 0);
         end else begin
            checkOutput("tick_cycle", cyc, expTicks[0]);
            void'(expTicks.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_clk_div", clk_div, 0);
      checkOutput("rst_tick", tick, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_cfg_ready", cfg_ready, 1);

      rst_n     = 1'b1;
      staticBad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (clk_div !== 1'b0 || tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1)
            staticBad++;
      end
      checkOutput("idle_static_cycles", staticBad, 0);

      // Ratio 3 loaded while stopped, then started.
      applyStimulus(1'b0, 1'b1, 16'd3);
      waitUntil(cyc + 1);
      applyStimulus(1'b1, 1'b0, 16'd0);
      checkOutput("start_busy_pre", busy, 0);
      checkOutput("start_cfg_ready", cfg_ready, 1);
      b = cyc + 1;
      expTicks.push_back(b + 4);
      expTicks.push_back(b + 8);
      expTicks.push_back(b + 12);
      expTicks.push_back(b + 18);
      expTicks.push_back(b + 24);
      expTicks.push_back(b + 28);
      waitUntil(b);
      checkOutput("start_busy", busy, 1);
      for (int k = 0; k < 8; k++) begin
         waitUntil(b + k);
         checkOutput($sformatf("t3_clk_div_%0d", k), clk_div, patA[k]);
      end

      // Ratio 5 offered mid-period: held pending until the wrap.
      waitUntil(b + 9);
      applyStimulus(1'b1, 1'b1, 16'd5);
      waitUntil(b + 10);
      applyStimulus(1'b1, 1'b0, 16'd0);
      checkOutput("pend_ready_c2", cfg_ready, 0);
      waitUntil(b + 11);
      checkOutput("pend_ready_c3", cfg_ready, 0);
      waitUntil(b + 12);
      checkOutput("pend_ready_applied", cfg_ready, 1);
      for (int k = 0; k < 12; k++) begin
         waitUntil(b + 12 + k);
         checkOutput($sformatf("t5_clk_div_%0d", k), clk_div, patB[k]);
      end

      // Ratio 3 offered on the wrap edge itself: applied directly.
      applyStimulus(1'b1, 1'b1, 16'd3);
      waitUntil(b + 24);
      applyStimulus(1'b1, 1'b0, 16'd0);
      checkOutput("wrap_cfg_ready", cfg_ready, 1);

      // Stop at counter 1: drains 2,3 then idles after the final tick.
      waitUntil(b + 25);
      applyStimulus(1'b0, 1'b0, 16'd0);
      waitUntil(b + 26);
      checkOutput("drain_busy_c2", busy, 1);
      checkOutput("drain_clk_div_c2", clk_div, 1);
      waitUntil(b + 27);
      checkOutput("drain_busy_c3", busy, 1);
      checkOutput("drain_clk_div_c3", clk_div, 1);
      waitUntil(b + 28);
      checkOutput("stop_busy", busy, 0);
      checkOutput("stop_clk_div", clk_div, 0);

      // Restart, then re-raise en during the drain: cadence must not slip.
      applyStimulus(1'b1, 1'b0, 16'd0);
      b3 = b + 29;
      expTicks.push_back(b3 + 4);
      expTicks.push_back(b3 + 8);
      expTicks.push_back(b3 + 12);
      expTicks.push_back(b3 + 14);
      expTicks.push_back(b3 + 16);
      expTicks.push_back(b3 + 18);
      expTicks.push_back(b3 + 20);
      waitUntil(b3 + 1);
      applyStimulus(1'b0, 1'b0, 16'd0);
      waitUntil(b3 + 2);
      applyStimulus(1'b1, 1'b0, 16'd0);
      checkOutput("redrain_busy", busy, 1);
      waitUntil(b3 + 3);
      checkOutput("rerun_busy", busy, 1);

      // Ratio 0 clamps to 1: divided clock toggles every cycle.
      waitUntil(b3 + 11);
      applyStimulus(1'b1, 1'b1, 16'd0);
      waitUntil(b3 + 12);
      applyStimulus(1'b1, 1'b0, 16'd0);
      checkOutput("clamp_cfg_ready", cfg_ready, 1);
      for (int k = 0; k < 8; k++) begin
         waitUntil(b3 + 12 + k);
         checkOutput($sformatf("t1_clk_div_%0d", k), clk_div, k & 1);
      end

      // Full-scale ratio: clk_div rises only once counter reaches 0x8000.
      applyStimulus(1'b1, 1'b1, 16'hFFFF);
      waitUntil(b3 + 20);
      applyStimulus(1'b1, 1'b0, 16'd0);
      checkOutput("max_cfg_ready", cfg_ready, 1);
      b5 = b3 + 20;
      waitUntil(b5 + 32767);
      checkOutput("max_clk_div_7fff", clk_div, 0);
      waitUntil(b5 + 32768);
      checkOutput("max_clk_div_8000", clk_div, 1);
      r = cyc;
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'd0);
      #1;
      checkOutput("rst1_clk_div", clk_div, 0);
      checkOutput("rst1_busy", busy, 0);

      // Reset while a config is pending must discard it.
      waitUntil(r + 2);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 16'd3);
      waitUntil(r + 3);
      applyStimulus(1'b1, 1'b0, 16'd0);
      b6 = r + 4;
      waitUntil(b6 + 1);
      applyStimulus(1'b1, 1'b1, 16'd5);
      waitUntil(b6 + 2);
      applyStimulus(1'b0, 1'b0, 16'd0);
      checkOutput("midrst_pend_ready", cfg_ready, 0);
      checkOutput("midrst_clk_div_pre", clk_div, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_clk_div", clk_div, 0);
      checkOutput("midrst_tick", tick, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_cfg_ready", cfg_ready, 1);
      checkOutput("midrst_ticks_left", expTicks.size(), 0);

      // Default ratio after reset: half period of 28094 cycles.
      waitUntil(b6 + 4);
      rst_n = 1'b1;
      waitUntil(b6 + 5);
      checkOutput("post_rst_cfg_ready", cfg_ready, 1);
      checkOutput("post_rst_busy", busy, 0);
      applyStimulus(1'b1, 1'b0, 16'd0);
      b7 = b6 + 6;
      waitUntil(b7 + 28093);
      checkOutput("def_clk_div_low", clk_div, 0);
      waitUntil(b7 + 28094);
      checkOutput("def_clk_div_high", clk_div, 1);
      checkOutput("def_busy", busy, 1);
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'd0);
      waitUntil(cyc + 2);
      checkOutput("ticks_left", expTicks.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Run-time controller for the board's counter-based clock divider. Owns the divide counter and its terminal value, sequences start/stop on period boundaries, and accepts new divide ratios through a valid/ready handshake applied glitch-free at the next wrap. Outputs a 50%-nominal divided clock plus a one-cycle tick per period, for use by the display-scan and slow-timer logic.

## Interface
- CNT_W, 16: width of counter, terminal value and config bus
- DEF_TERM, 56187: terminal count after reset (period = DEF_TERM+1 cycles)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  level run request
- cfg_valid  in  1  new terminal value offered
- cfg_div  in  CNT_W  requested terminal value (period = cfg_div+1)
- cfg_ready  out  1  controller can accept cfg_div
- clk_div  out  1  registered divided clock
- tick  out  1  one-cycle pulse per completed period
- busy  out  1  state is not IDLE

## Operation
- Registers: counter, term, half = (term+1)>>1, pend (CNT_W), pend_v, state, tick, clk_div.
- States: IDLE, RUN, DRAIN. busy = (state != IDLE).
- IDLE: counter held 0, clk_div 0. en=1 -> RUN; counter is 0 in first RUN cycle.
- RUN: counter +1 each cycle; at counter==term, counter <= 0 (wrap). en=0 -> DRAIN.
- DRAIN: counts as RUN. en=1 -> RUN, no disturbance to counter. Wrap with en=0 -> IDLE, counter 0.
- Wrap always issues tick, including the final wrap out of DRAIN.
- clk_div = (counter >= half), registered from next-counter value so it is aligned with counter and glitch-free. Low for half cycles, high for term+1-half cycles.
- Config: cfg_ready = !pend_v. Transfer = cfg_valid && cfg_ready.
  - Transfer in IDLE, or on the same edge as a wrap: term/half updated on that edge directly, pend_v stays 0.
  - Transfer otherwise: value into pend, pend_v=1; at next wrap term <= pend, half recomputed, pend_v <= 0.
- cfg_div = 0 clamped to 1 (minimum period 2).
- half is computed in CNT_W+1 bits; term = all-ones is legal.

## Timing
- Reset values: counter 0, term DEF_TERM, half (DEF_TERM+1)>>1, state IDLE, pend_v 0, tick 0, clk_div 0, cfg_ready 1, busy 0.
- en sampled at edge E0 -> busy=1 after E0; wrap at edge E0+term+1; tick high for the cycle after that edge.
- Period after enable is exactly term+1 cycles, first period included.
- New term takes effect from the counter=0 cycle following the applying wrap; cfg_ready returns high in that same cycle.
- Stop latency: from en fall to IDLE is remaining cycles to wrap +1 edge; partial periods never occur.
- Reset asserted mid-operation: all registers clear immediately (asynchronous). Pending config is discarded.

## Configuration
- DIV_CTRL_WRAP_CNT_EN defined: extra output wrap_cnt (16 bits) counts ticks, saturates at 0xFFFF, clears to 0 on IDLE->RUN and at reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: hold rst_n=0 -> clk_div=0, tick=0, busy=0, cfg_ready=1. Release with en=0 -> outputs static for 100 cycles.
- In IDLE send cfg_div=3, then en=1 -> clk_div pattern 0,0,1,1 repeating; tick every 4 cycles, first tick 4 cycles after busy rises.
- Term 3 running, send cfg_div=5 at counter=1 -> cfg_ready low until wrap; the current period stays 4. Following periods are 6 cycles, with clk_div low 3/high 3.
- Term 3, drop en at counter=1 -> counts 2,3, final tick issued, busy falls after the wrap edge. Re-raise en during DRAIN -> no gap in period.
- cfg_div=0 -> period 2, clk_div toggles every cycle. cfg_div=0xFFFF accepted, with half=0x8000.
- Assert rst_n=0 at counter=2 with pend_v=1 -> all outputs clear at once. After release, term=56187 and pend_v=0.
